// File: rtl/mem_access_unit.sv
// mem_access_unit - MEM-stage load/store engine.
//
// Consumes the EX/MEM register outputs, runs one request/grant/response
// transaction per memory op on the data bus, steers store data onto byte
// lanes, sign/zero-extends load data, stalls upstream while a transaction
// is in flight, and hands the final write-back bundle to MEM/WB.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   mem_op_i/we/addr/data   memory op, store flag, byte address, store data
//   reg_waddr/we/wdata_i    register write bundle from EX/MEM
//   dbus_*_o / dbus_*_i     data bus request side / grant + response side
//   stall_o                 hold IF..EX/MEM
//   misalign_o, bus_err_o   one-cycle exception pulses
//   reg_waddr/we/wdata_o    write-back bundle to MEM/WB
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             mem_op_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
  output logic [3:0]             dbus_be_o,
  output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
  input  logic                   dbus_gnt_i,
  input  logic                   dbus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
  output logic                   stall_o,
  output logic                   misalign_o,
  output logic                   bus_err_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o
);

  localparam logic [3:0] OP_LB  = 4'd1, OP_LH  = 4'd2, OP_LW = 4'd3,
                         OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6,
                         OP_SH  = 4'd7, OP_SW  = 4'd8;
  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] load_data;
  logic [CNT_W-1:0]      cnt;
  logic                  err;
  logic                  done_load;

  logic       is_load, is_store, is_half, is_word, active, misaligned;
  logic [1:0] off;

  // The store flag duplicates information already carried by mem_op_i.
  logic unused_we;
  assign unused_we = mem_we_i;

  function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] o);
    case (op)
      OP_SB:   lane_be = 4'b0001 << o;
      OP_SH:   lane_be = 4'b0011 << {o[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   lane_wdata = {4{d[7:0]}};
      OP_SH:   lane_wdata = {2{d[15:0]}};
      OP_SW:   lane_wdata = d;
      default: lane_wdata = '0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] o,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{o, 3'b000} +: 8];
    h = o[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'd0, b};
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'd0, h};
      default: load_extend = rdata;
    endcase
  endfunction

  always_comb begin
    is_load    = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LHU);
    is_store   = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    is_half    = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
    is_word    = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    active     = is_load || is_store;
    off        = mem_addr_i[1:0];
    misaligned = (is_half && off[0]) || (is_word && (off != 2'b00));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      load_data <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      done_load <= 1'b0;
    end else begin
      case (state)
        IDLE, WAIT_GNT: begin
          if (state == WAIT_GNT || (active && !misaligned)) begin
            err       <= 1'b0;
            done_load <= is_load;
            cnt       <= '0;
            if (dbus_gnt_i) state <= is_load ? WAIT_RSP : DONE;
            else            state <= WAIT_GNT;
          end
        end
        WAIT_RSP: begin
          cnt <= cnt + 1'b1;
          // A response arriving on the timeout cycle still wins.
          if (dbus_rvalid_i) begin
            load_data <= load_extend(mem_op_i, off, dbus_rdata_i);
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_be_o    = 4'b0000;
    dbus_wdata_o = '0;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    reg_waddr_o  = '0;
    reg_we_o     = 1'b0;
    reg_wdata_o  = '0;
    // Every output is forced low while reset is held, even combinational paths.
    if (!rst_i) begin
      reg_waddr_o = reg_waddr_i;
      reg_we_o    = reg_we_i;
      reg_wdata_o = reg_wdata_i;
      case (state)
        IDLE: begin
          if (active && misaligned) begin
            misalign_o = 1'b1;
            reg_we_o   = 1'b0;
          end else if (active) begin
            dbus_req_o = 1'b1;
            stall_o    = 1'b1;
            reg_we_o   = 1'b0;
          end
        end
        WAIT_GNT: begin
          dbus_req_o = 1'b1;
          stall_o    = 1'b1;
          reg_we_o   = 1'b0;
        end
        WAIT_RSP: begin
          stall_o  = 1'b1;
          reg_we_o = 1'b0;
        end
        DONE: begin
          if (err) begin
            bus_err_o = 1'b1;
            reg_we_o  = 1'b0;
          end else if (done_load) begin
            reg_wdata_o = load_data;
          end else begin
            reg_we_o = 1'b0;
          end
        end
        default: ;
      endcase
      // Bus fields are only meaningful while a request is raised; upstream
      // holds its inputs during the stall so they stay stable in WAIT_GNT.
      if (dbus_req_o) begin
        dbus_we_o    = is_store;
        dbus_addr_o  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
        dbus_be_o    = lane_be(mem_op_i, off);
        dbus_wdata_o = lane_wdata(mem_op_i, mem_data_i);
      end
    end
  end

endmodule
